// File: rtl/ifmap_spad.sv
// Input-feature-map scratchpad: circular buffer that replays sliding windows of K elements to a MAC.
// Optional completed-window counter output win_cnt is enabled by defining IFMAP_SPAD_WIN_CNT_EN.
module ifmap_spad #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CW-1:0]     cfg_k,
   input  logic [CW-1:0]     cfg_stride,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              out_last,
`ifdef IFMAP_SPAD_WIN_CNT_EN
   output logic [15:0]       win_cnt,
`endif
   input  logic              flush
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      S_WAIT   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready never depends on out_ready, so a full buffer cannot accept an element in the pop cycle.

   state_t              state;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wp;
   logic [AW-1:0]       bp;
   logic [AW-1:0]       off;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       k_r;
   logic [CW-1:0]       s_r;

   logic [CW-1:0]       k_c;
   logic [CW-1:0]       s_c;
   logic [CW-1:0]       cnt_n;
   logic [AW-1:0]       rd_addr;
   logic                streaming;
   logic                in_fire;
   logic                out_fire;
   logic                win_done;

   // Config clamping: K into [1, DEPTH], stride into [1, K].
   always_comb begin
      k_c = cfg_k;
      if (cfg_k == '0)
         k_c = CW'(1);
      else if (cfg_k > CW'(DEPTH))
         k_c = CW'(DEPTH);
      s_c = cfg_stride;
      if (cfg_stride == '0)
         s_c = CW'(1);
      else if (cfg_stride > k_c)
         s_c = k_c;
   end

   always_comb begin
      in_ready  = (cnt < CW'(DEPTH)) & ~rst;
      in_fire   = in_valid & in_ready;
      streaming = (state == S_STREAM) & ~rst;
      rd_addr   = bp + off;
      out_valid = streaming;
      out_data  = streaming ? mem[rd_addr] : '0;
      out_last  = streaming & (CW'(off) == (k_r - CW'(1)));
      out_fire  = out_valid & out_ready;
      win_done  = out_fire & out_last;
   end

   // Occupancy: a push and a window retirement in the same cycle net to +1 - stride.
   always_comb begin
      cnt_n = cnt;
      if (in_fire)
         cnt_n = cnt_n + CW'(1);
      if (win_done)
         cnt_n = cnt_n - s_r;
   end

   // Storage is deliberately left out of reset and flush.
   always_ff @(posedge clk) begin
      if (in_fire && !flush)
         mem[wp] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state <= S_WAIT;
         wp    <= '0;
         bp    <= '0;
         off   <= '0;
         cnt   <= '0;
         k_r   <= CW'(1);
         s_r   <= CW'(1);
      end else begin
         cnt <= cnt_n;
         if (in_fire)
            wp <= wp + AW'(1);
         case (state)
            S_WAIT: begin
               k_r <= k_c;
               s_r <= s_c;
               off <= '0;
               if (cnt >= k_c)
                  state <= S_STREAM;
            end
            S_STREAM: begin
               if (out_fire) begin
                  if (out_last) begin
                     bp    <= bp + AW'(s_r);
                     off   <= '0;
                     state <= S_WAIT;
                  end else begin
                     off <= off + AW'(1);
                  end
               end
            end
            default: state <= S_WAIT;
         endcase
      end
   end

`ifdef IFMAP_SPAD_WIN_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || flush)
         win_cnt <= '0;
      else if (win_done)
         win_cnt <= win_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ifmap_spad.sv
// Directed bench for ifmap_spad: expected window elements go into a queue, a monitor pops on every output transfer.
module tb_ifmap_spad;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int W      = DATA_W + 1;

   logic              clk;
   logic              rst;
   logic [CW-1:0]     cfg_k;
   logic [CW-1:0]     cfg_stride;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              out_last;
   logic              flush;
`ifdef IFMAP_SPAD_WIN_CNT_EN
   logic [15:0]       win_cnt;
`endif

   int vectors = 0;
   int errors  = 0;
   logic [W-1:0] exp_q[$];

   ifmap_spad #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_k      (cfg_k),
      .cfg_stride (cfg_stride),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .out_last   (out_last),
`ifdef IFMAP_SPAD_WIN_CNT_EN
      .win_cnt    (win_cnt),
`endif
      .flush      (flush)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got data=%0d last=%0b expected nothing", out_data, out_last);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
               errors++;
               $display("FAIL window_elem: got data=%0d last=%0b expected data=%0d last=%0b",
                        out_data, out_last, e[DATA_W-1:0], e[W-1]);
            end
         end
      end
   end

   // driver tasks (all entered and left at posedge+1)
   task automatic ex(input int d, input bit last);
      exp_q.push_back({last, DATA_W'(d)});
   endtask

   task automatic push(input int d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = DATA_W'(d);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("push_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         chk({name, "_drain_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_out_valid"}, int'(out_valid), 1);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic cfg(input int k, input int s);
      cfg_k      = CW'(k);
      cfg_stride = CW'(s);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; cfg_k = CW'(3); cfg_stride = CW'(1);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);

      // K=3 S=1, free-running consumer
      cfg(3, 1); out_ready = 1'b1;
      ex(1,0); ex(2,0); ex(3,1); ex(2,0); ex(3,0); ex(4,1); ex(3,0); ex(4,0); ex(5,1);
      for (int i = 1; i <= 5; i++) push(i);
      drain("k3s1");
      repeat (2) @(posedge clk); #1;
      chk("k3s1_cnt", int'(dut.cnt), 2);
      chk("k3s1_out_valid", int'(out_valid), 0);
`ifdef IFMAP_SPAD_WIN_CNT_EN
      chk("k3s1_win_cnt", int'(win_cnt), 3);
`endif
      do_flush();

      // K=3 S=3
      cfg(3, 3);
      ex(1,0); ex(2,0); ex(3,1); ex(4,0); ex(5,0); ex(6,1);
      for (int i = 1; i <= 6; i++) push(i);
      drain("k3s3");
      repeat (2) @(posedge clk); #1;
      chk("k3s3_cnt", int'(dut.cnt), 0);
      chk("k3s3_out_valid", int'(out_valid), 0);
      do_flush();

      // fill to DEPTH without draining, then retire one window
      cfg(3, 1); out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(100 + i);
      @(negedge clk);
      chk("full_cnt", int'(dut.cnt), 16);
      chk("full_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      ex(100,0); ex(101,0); ex(102,1);
      out_ready = 1'b1;
      drain("full");
      out_ready = 1'b0;
      chk("full_retire_cnt", int'(dut.cnt), 15);
      chk("full_retire_in_ready", int'(in_ready), 1);
      do_flush();

      // stall pattern 1,0,0,1 mid-window
      cfg(4, 4); out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(10 * i);
      wait_valid("stall");
      ex(10,0); ex(20,0); ex(30,0); ex(40,1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stall_data_held", int'(out_data), 20);
         chk("stall_last_held", int'(out_last), 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      drain("stall");
      out_ready = 1'b0;
      do_flush();

      // cfg_stride=0 clamps to 1
      cfg(3, 0); out_ready = 1'b1;
      ex(1,0); ex(2,0); ex(3,1); ex(2,0); ex(3,0); ex(4,1);
      for (int i = 1; i <= 4; i++) push(i);
      drain("s0");
      repeat (2) @(posedge clk); #1;
      chk("s0_cnt", int'(dut.cnt), 2);
      do_flush();

      // cfg_stride=5 clamps to K=3
      cfg(3, 5);
      ex(1,0); ex(2,0); ex(3,1); ex(4,0); ex(5,0); ex(6,1);
      for (int i = 1; i <= 6; i++) push(i);
      drain("s5");
      repeat (2) @(posedge clk); #1;
      chk("s5_cnt", int'(dut.cnt), 0);
      do_flush();

      // cfg_k changed while a window is open
      cfg(3, 3); out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) push(i);
      wait_valid("kchg");
      cfg(2, 3);
      ex(1,0); ex(2,0); ex(3,1);
      out_ready = 1'b1;
      drain("kchg");
      out_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("kchg_cnt", int'(dut.cnt), 0);
      do_flush();

      // flush at off=1
      cfg(3, 1);
      for (int i = 7; i <= 9; i++) push(i);
      wait_valid("flush");
      ex(7,0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("flush_off", int'(dut.off), 1);
      do_flush();
      chk("flush_cnt", int'(dut.cnt), 0);
      chk("flush_out_valid", int'(out_valid), 0);
`ifdef IFMAP_SPAD_WIN_CNT_EN
      chk("flush_win_cnt", int'(win_cnt), 0);
`endif

      // rst at off=1
      for (int i = 7; i <= 9; i++) push(i);
      wait_valid("rst");
      ex(7,0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("rst_off", int'(dut.off), 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", int'(out_valid), 0);
      chk("rst_mid_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_cnt", int'(dut.cnt), 0);
      chk("rst_out_valid_after", int'(out_valid), 0);
      chk("rst_in_ready_after", int'(in_ready), 1);
`ifdef IFMAP_SPAD_WIN_CNT_EN
      chk("rst_win_cnt", int'(win_cnt), 0);
`endif
      repeat (3) @(posedge clk); #1;
      chk("leftover_expected", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
